// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_RDY = 2'd1,
        GAP      = 2'd2,
        DONE     = 2'd3
    } rst_seq_state_t;

    typedef enum logic {
        CAUSE_SYS  = 1'b0,
        CAUSE_SOFT = 1'b1
    } rst_cause_t;

    // Largest of three cycle counts; sizes the one counter shared by every state.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/rst_seq.sv
// Staged reset sequencer: holds every domain in reset, then releases the
// stages one at a time in ascending order. Each release waits for that stage
// to report ready (or time out), followed by an optional idle gap.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int HOLD_CYC   = 16,
    parameter int GAP_CYC    = 8,
    parameter int TMO_CYC    = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic                  rst_cause
);

    localparam int CNT_W = $clog2(maxOf3(HOLD_CYC, GAP_CYC, TMO_CYC) + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam bit               HAS_GAP   = (GAP_CYC > 0);

    rst_seq_state_t          r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_STAGES-1:0]   r_stageRst;
    logic                    r_seqDone;
    logic                    r_seqErr;
    rst_cause_t              r_rstCause;

    logic [IDX_W-1:0]        w_idxNext;
    logic                    w_curReady;
    logic                    w_tmoHit;
    logic                    w_handled;
    logic [NUM_STAGES-1:0]   w_curMask;
    logic [NUM_STAGES-1:0]   w_nextMask;

    // A stage is handled when it reports ready; the timeout only counts when ready is still low.
    assign w_idxNext  = r_idx + 1'b1;
    assign w_curReady = stage_ready[r_idx];
    assign w_tmoHit   = (r_cnt == TMO_LAST);
    assign w_handled  = w_curReady || w_tmoHit;
    assign w_curMask  = NUM_STAGES'(1) << r_idx;
    assign w_nextMask = NUM_STAGES'(1) << w_idxNext;

    // Sequencer FSM: sys_rst beats a soft request, and both restart from a full hold.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stageRst <= '1;
            r_seqDone  <= 1'b0;
            r_seqErr   <= 1'b0;
            r_rstCause <= CAUSE_SYS;
        end else if (soft_rst_req) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stageRst <= '1;
            r_seqDone  <= 1'b0;
            r_seqErr   <= 1'b0;
            r_rstCause <= CAUSE_SOFT;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_stageRst <= r_stageRst & ~w_curMask;
                        r_cnt      <= '0;
                        r_state    <= WAIT_RDY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (w_handled) begin
                        if (!w_curReady) begin
                            r_seqErr <= 1'b1;
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state   <= DONE;
                            r_seqDone <= 1'b1;
                        end else if (HAS_GAP) begin
                            r_state <= GAP;
                            r_cnt   <= '0;
                        end else begin
                            r_idx      <= w_idxNext;
                            r_stageRst <= r_stageRst & ~w_nextMask;
                            r_cnt      <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_idx      <= w_idxNext;
                        r_stageRst <= r_stageRst & ~w_nextMask;
                        r_cnt      <= '0;
                        r_state    <= WAIT_RDY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign stage_rst = r_stageRst;
    assign seq_done  = r_seqDone;
    assign seq_err   = r_seqErr;
    assign rst_cause = r_rstCause;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: two instances (GAP_CYC=4 and GAP_CYC=0) share
// stimulus; a schedule model predicts every output change per instance.
module tb_rst_seq;

    localparam int NS   = 4;
    localparam int HOLD = 8;
    localparam int GAPN = 4;
    localparam int TMO  = 32;
    localparam int INF  = 1 << 30;

    typedef struct {
        int         at;
        bit         sel;
        logic [3:0] rst;
        logic       done;
        logic       err;
        logic       cause;
    } ev_t;

    logic       clk = 1'b0;
    logic       sysRst = 1'b1;
    logic       softReq = 1'b0;
    logic [3:0] stageReady = '0;

    logic [3:0] rstG4, rstG0;
    logic       doneG4, doneG0, errG4, errG0, causeG4, causeG0;

    int  cyc = 0;
    int  rdyEdge [4] = '{default: 0};
    ev_t q [$];
    ev_t curExp [2];
    bit  expValid [2] = '{default: 1'b0};
    bit  popped [2];
    int  nChecks = 0;
    int  nFails  = 0;

    rst_seq #(.NUM_STAGES(NS), .HOLD_CYC(HOLD), .GAP_CYC(GAPN), .TMO_CYC(TMO)) dutG4 (
        .sys_clk(clk), .sys_rst(sysRst), .soft_rst_req(softReq), .stage_ready(stageReady),
        .stage_rst(rstG4), .seq_done(doneG4), .seq_err(errG4), .rst_cause(causeG4));

    rst_seq #(.NUM_STAGES(NS), .HOLD_CYC(HOLD), .GAP_CYC(0), .TMO_CYC(TMO)) dutG0 (
        .sys_clk(clk), .sys_rst(sysRst), .soft_rst_req(softReq), .stage_ready(stageReady),
        .stage_rst(rstG0), .seq_done(doneG0), .seq_err(errG0), .rst_cause(causeG0));

    always #5 clk = ~clk;

    // Edge number: after the k-th rising edge cyc==k.
    always @(posedge clk) cyc <= cyc + 1;

    // Each stage's ready rises at its scheduled edge and stays high.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) stageReady[i] = ((cyc + 1) >= rdyEdge[i]);
    end

    // Expected outputs right after edge e of a sequence whose reset/request was sampled at edge s.
    function automatic ev_t expAt(input int e, input int s, input bit cause, input int gap, input bit sel);
        ev_t r;
        int  t;
        int  rel [4];
        int  hnd [4];
        bit  to [4];
        t = s + HOLD;
        for (int i = 0; i < NS; i++) begin
            rel[i] = t;
            if (rdyEdge[i] <= t + 1)        hnd[i] = t + 1;
            else if (rdyEdge[i] <= t + TMO) hnd[i] = rdyEdge[i];
            else                            hnd[i] = t + TMO;
            to[i] = (rdyEdge[i] > t + TMO);
            t = hnd[i] + gap;
        end
        r.at = e; r.sel = sel; r.cause = cause; r.err = 1'b0;
        for (int i = 0; i < NS; i++) begin
            r.rst[i] = (e < rel[i]);
            if (to[i] && hnd[i] <= e) r.err = 1'b1;
        end
        r.done = (e >= hnd[NS-1]);
        return r;
    endfunction

    function automatic bit sameOut(input ev_t a, input ev_t b);
        return (a.rst === b.rst) && (a.done === b.done) && (a.err === b.err) && (a.cause === b.cause);
    endfunction

    function automatic ev_t sampleDut(input bit sel);
        ev_t r;
        r.at = cyc; r.sel = sel;
        if (!sel) begin r.rst = rstG4; r.done = doneG4; r.err = errG4; r.cause = causeG4; end
        else      begin r.rst = rstG0; r.done = doneG0; r.err = errG0; r.cause = causeG0; end
        return r;
    endfunction

    task automatic flushFrom(input int cut);
        while (q.size() > 0 && q[q.size()-1].at >= cut) void'(q.pop_back());
    endtask

    task automatic pushSchedule(input int s, input bit cause);
        ev_t prev [2];
        ev_t cur;
        for (int e = s; e <= s + HOLD + NS * (TMO + GAPN + 1) + 2; e++) begin
            for (int sel = 0; sel < 2; sel++) begin
                cur = expAt(e, s, cause, (sel == 0) ? GAPN : 0, sel[0]);
                if (e == s || !sameOut(cur, prev[sel])) q.push_back(cur);
                prev[sel] = cur;
            end
        end
    endtask

    // Drive sys_rst/soft request for nCyc edges and queue the predicted response.
    task automatic applyStimulus(input bit doSys, input bit doSoft, input int nCyc);
        int s0, sLast;
        bit cause;
        cause = doSys ? 1'b0 : 1'b1;
        @(negedge clk);
        s0 = cyc + 1;
        sLast = s0 + nCyc - 1;
        flushFrom(s0);
        if (nCyc > 1) begin
            q.push_back(expAt(s0, sLast, cause, GAPN, 1'b0));
            q.push_back(expAt(s0, sLast, cause, 0, 1'b1));
        end
        pushSchedule(sLast, cause);
        sysRst = doSys;
        softReq = doSoft;
        repeat (nCyc) @(negedge clk);
        sysRst = 1'b0;
        softReq = 1'b0;
    endtask

    task automatic checkOutput(input ev_t got, input ev_t exp, input string tag);
        nChecks++;
        if (!sameOut(got, exp)) begin
            nFails++;
            $display("[TB] FAIL %s dut=%s edge=%0d: got rst=%b done=%b err=%b cause=%b, required rst=%b done=%b err=%b cause=%b",
                     tag, exp.sel ? "gap0" : "gap4", cyc, got.rst, got.done, got.err, got.cause,
                     exp.rst, exp.done, exp.err, exp.cause);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: %0d expected events still pending, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pop events due on this edge and compare; between events outputs must hold.
    always @(negedge clk) begin
        popped[0] = 1'b0;
        popped[1] = 1'b0;
        while (q.size() > 0 && q[0].at < cyc) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL stale: event for edge %0d not consumed, now edge %0d", q[0].at, cyc);
            void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].at == cyc) begin
            ev_t x;
            x = q.pop_front();
            checkOutput(sampleDut(x.sel), x, "event");
            curExp[x.sel] = x;
            expValid[x.sel] = 1'b1;
            popped[x.sel] = 1'b1;
        end
        for (int sel = 0; sel < 2; sel++) begin
            if (expValid[sel] && !popped[sel] && !sameOut(sampleDut(sel[0]), curExp[sel]))
                checkOutput(sampleDut(sel[0]), curExp[sel], "steady");
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind;
        applyStimulus(1'b1, 1'b0, 3);
        drain();

        rdyEdge[2] = INF;
        applyStimulus(1'b1, 1'b0, 2);
        drain();

        rdyEdge[2] = 0;
        applyStimulus(1'b0, 1'b1, 1);
        drain();

        applyStimulus(1'b0, 1'b1, 1);
        repeat (14) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1);
        drain();

        applyStimulus(1'b0, 1'b1, 1);
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1);
        drain();

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NS; i++)
                rdyEdge[i] = ($urandom_range(0, 3) == 0) ? INF : cyc + int'($urandom_range(0, 70));
            kind = int'($urandom_range(0, 2));
            if (kind == 0)      applyStimulus(1'b1, 1'b0, int'($urandom_range(1, 3)));
            else if (kind == 1) applyStimulus(1'b0, 1'b1, 1);
            else                applyStimulus(1'b1, 1'b1, 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
                applyStimulus(1'b0, 1'b1, 1);
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer placed directly after the clock/reset generator in the `sys_clk` domain. It takes the synchronized system reset plus a software reset request and releases per-domain resets (e.g. CPU, DSP/NCO chain, ADC, DAC) one stage at a time in ascending index order. Before the next stage is released, each stage must report ready (or time out). It reports completion, a sticky timeout error and the cause of the last reset sequence.

## Interface
- `NUM_STAGES`, 4: number of reset stages (1..8)
- `HOLD_CYC`, 16: cycles all stages stay in reset after the sequence starts (>=1)
- `GAP_CYC`, 8: idle cycles between a stage becoming ready and the next stage release (>=0)
- `TMO_CYC`, 1024: max cycles to wait for `stage_ready[i]` (>=1)
- `sys_clk`  in  1  system clock; the only clock
- `sys_rst`  in  1  reset, synchronous to `sys_clk`, active-high
- `soft_rst_req`  in  1  single-cycle software reset request (CSR strobe)
- `stage_ready`  in  NUM_STAGES  per-stage "init done", level, `sys_clk` domain
- `stage_rst`  out  NUM_STAGES  per-stage reset, active-high, registered
- `seq_done`  out  1  all stages released and handled
- `seq_err`  out  1  sticky: at least one stage timed out in current sequence
- `rst_cause`  out  1  0 = last sequence started by `sys_rst`, 1 = by `soft_rst_req`

## Operation
- States: HOLD, WAIT_RDY, GAP, DONE. Index `idx` (0..NUM_STAGES-1) and one shared cycle counter `cnt`.
- Reset (`sys_rst`=1): state=HOLD, idx=0, cnt=0, `stage_rst`=all 1, `seq_done`=0, `seq_err`=0, `rst_cause`=0.
- HOLD: cnt increments each cycle. At cnt==HOLD_CYC-1: clear `stage_rst[idx]`, cnt=0, go to WAIT_RDY.
- WAIT_RDY: `stage_ready[idx]` sampled each cycle.
  - If it is 1, or if cnt==TMO_CYC-1, the stage is handled. On a timeout, `seq_err`<=1.
  - Handled with idx==NUM_STAGES-1: go to DONE and set `seq_done`=1.
  - Handled otherwise, GAP_CYC>0: go to GAP with cnt=0.
  - Handled otherwise, GAP_CYC==0: idx++ and clear `stage_rst[idx+1]` in the same cycle. Stay in WAIT_RDY with cnt=0.
  - Not handled: cnt++.
- GAP: cnt increments. At cnt==GAP_CYC-1: idx++, clear `stage_rst[idx]`, cnt=0, go to WAIT_RDY.
- DONE: hold. `stage_ready` changes are ignored; no automatic re-sequencing.
- `soft_rst_req`=1 in any state:
  - `stage_rst`=all 1, idx=0, cnt=0, `seq_done`=0, `seq_err`=0, `rst_cause`=1, then enter HOLD.
  - A request during HOLD restarts the hold count.
- `sys_rst` together with `soft_rst_req`: `sys_rst` wins and `rst_cause`=0.
- Released stages stay released until the next reset or soft request. `stage_rst` bits only go 1->0 one at a time, in ascending order.
- Counter width is $clog2(max(HOLD_CYC,GAP_CYC,TMO_CYC)+1). No wrap is possible because each terminal compare exits the state.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- `stage_rst[0]` stays high for exactly HOLD_CYC cycles after the first edge where `sys_rst` (or the soft request) is sampled low/deasserted.
- With `stage_ready[i]` already high at release, the release-to-release spacing is 1+GAP_CYC cycles.
- With ready never asserted, stage i is held in WAIT_RDY for exactly TMO_CYC cycles.
- `seq_done` rises on the edge that samples the last stage handled. At that point `seq_err` is final.
- Soft request latency: `stage_rst`=all 1 on the edge after the strobe is sampled.

## Structure
- `rst_seq_pkg`:
  - `rst_seq_state_t` enum {HOLD, WAIT_RDY, GAP, DONE}
  - `rst_cause_t` enum {CAUSE_SYS=1'b0, CAUSE_SOFT=1'b1}
- Single module, no sub-module. The FSM, shared counter and index register are small enough to keep flat.

## Test plan
Bench parameters: NUM_STAGES=4, HOLD_CYC=8, GAP_CYC=4, TMO_CYC=32.
- Power-on, `stage_ready`=4'hF -> `stage_rst` falls at cycles 8, 13, 18, 23 after `sys_rst` deasserts. `seq_done`=1 at cycle 24. `seq_err`=0, `rst_cause`=0.
- `stage_ready[2]` stuck 0 -> stage 2 waits 32 cycles, then stage 3 is released. `seq_err`=1 and `seq_done`=1.
- `soft_rst_req` pulse while in DONE -> `stage_rst`=4'hF next cycle, `seq_done`=0, `seq_err` cleared, `rst_cause`=1, then the same release schedule as power-on.
- `soft_rst_req` mid-GAP after stage 1 release, then repeated during HOLD at cycle 5 -> all stages reasserted. `stage_rst[0]` falls 8 cycles after the second request.
- `sys_rst` and `soft_rst_req` in the same cycle, mid-sequence -> all outputs at reset values, `rst_cause`=0.
- GAP_CYC=0 build, ready high -> stage releases on consecutive cycles 8, 9, 10, 11.
